// File: rtl/key_pkg.sv
// Shared constants for the key debouncer: key indices, default timing and counter sizing.
package key_pkg;

  localparam int unsigned KEY_LEFT  = 0;
  localparam int unsigned KEY_RIGHT = 1;
  localparam int unsigned KEY_UP    = 2;
  localparam int unsigned KEY_FIRE  = 3;

  // 50 MHz board timing: 5 ms debounce, 0.5 s first repeat, 0.1 s repeat period.
  localparam int unsigned DebounceCycles50M = 250000;
  localparam int unsigned RepeatDelay50M    = 25000000;
  localparam int unsigned RepeatRate50M     = 5000000;

  localparam int unsigned DebounceCyclesSim = 8;
  localparam int unsigned RepeatDelaySim    = 20;
  localparam int unsigned RepeatRateSim     = 6;

  // Width that can hold 0 .. n-1; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchronizer, counter debounce filter, press/release strobes.
// Auto-repeat press strobes are built only when KEY_AUTOREPEAT_EN is defined.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned DebounceCycles = DebounceCyclesSim,
  parameter bit          ActiveLow      = 1'b1,
  parameter int unsigned RepeatDelay    = RepeatDelaySim,
  parameter int unsigned RepeatRate     = RepeatRateSim
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic pin_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned     CntW   = cnt_width(DebounceCycles);
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  logic            sync1_q, sync2_q;
  logic            s_q, s_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            n;

  assign n = sync2_q ^ ActiveLow;

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned    RcMax    = (RepeatDelay > RepeatRate) ? RepeatDelay : RepeatRate;
  localparam int unsigned    RcW      = cnt_width(RcMax);
  localparam logic [RcW-1:0] DelayEnd = RcW'(RepeatDelay - 1);
  localparam logic [RcW-1:0] RateEnd  = RcW'(RepeatRate - 1);

  logic [RcW-1:0] rc_q, rc_d;
  logic           rep_q, rep_d;
`else
  logic unused_repeat;
  assign unused_repeat = ^{RepeatDelay, RepeatRate};
`endif

  always_comb begin
    s_d       = s_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (n == s_q) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntW'(1);
    end else begin
      s_d       = n;
      cnt_d     = '0;
      press_d   = n;
      release_d = ~n;
    end
`ifdef KEY_AUTOREPEAT_EN
    rc_d  = rc_q;
    rep_d = rep_q;
    // rc_q is 0 in the first cycle the key reads pressed, so the first repeat lands RepeatDelay later.
    if (!s_q || (s_d != s_q)) begin
      rc_d  = '0;
      rep_d = 1'b0;
    end else if ((!rep_q && rc_q == DelayEnd) || (rep_q && rc_q == RateEnd)) begin
      press_d = 1'b1;
      rc_d    = '0;
      rep_d   = 1'b1;
    end else begin
      rc_d = rc_q + RcW'(1);
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q   <= ActiveLow;
      sync2_q   <= ActiveLow;
      s_q       <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      rc_q      <= '0;
      rep_q     <= 1'b0;
`endif
    end else begin
      sync1_q   <= pin_i;
      sync2_q   <= sync1_q;
      s_q       <= s_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
`ifdef KEY_AUTOREPEAT_EN
      rc_q      <= rc_d;
      rep_q     <= rep_d;
`endif
    end
  end

  assign level_o   = s_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/key_debouncer.sv
// Debounces NKEYS raw button pins into clean levels plus press/release strobes.
// Optional auto-repeat press strobes: define KEY_AUTOREPEAT_EN.
module key_debouncer
  import key_pkg::*;
#(
  parameter int unsigned NKEYS           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCycles50M,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned REPEAT_DELAY    = RepeatDelay50M,
  parameter int unsigned REPEAT_RATE     = RepeatRate50M
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NKEYS-1:0] keys_raw,
  output logic [NKEYS-1:0] keys,
  output logic [NKEYS-1:0] keys_press,
  output logic [NKEYS-1:0] keys_release
);

  for (genvar i = 0; i < NKEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DebounceCycles (DEBOUNCE_CYCLES),
      .ActiveLow      (ACTIVE_LOW),
      .RepeatDelay    (REPEAT_DELAY),
      .RepeatRate     (REPEAT_RATE)
    ) u_ch (
      .clk_i     (clk),
      .reset_i   (reset),
      .pin_i     (keys_raw[i]),
      .level_o   (keys[i]),
      .press_o   (keys_press[i]),
      .release_o (keys_release[i])
    );
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Scoreboard bench for key_debouncer with sim timing (debounce 8, repeat 20/6, active-low pins).
module tb_key_debouncer;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  press;
    logic [3:0]  rel;
    logic [3:0]  keys;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] keys_raw = 4'b1111;
  logic [3:0] keys, keys_press, keys_release;

  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;
  exp_t        sb[$];

  key_debouncer #(
    .NKEYS           (4),
    .DEBOUNCE_CYCLES (8),
    .ACTIVE_LOW      (1'b1),
    .REPEAT_DELAY    (20),
    .REPEAT_RATE     (6)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .keys_raw     (keys_raw),
    .keys         (keys),
    .keys_press   (keys_press),
    .keys_release (keys_release)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int unsigned c, input logic [3:0] p, input logic [3:0] r,
                      input logic [3:0] k);
    exp_t e;
    e.cyc = c; e.press = p; e.rel = r; e.keys = k;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    tests++;
    if (keys !== 4'b0 || keys_press !== 4'b0 || keys_release !== 4'b0) begin
      fails++;
      $display("FAIL %s: keys=%b press=%b release=%b, required all 0", name, keys, keys_press,
               keys_release);
    end
  endtask

  // Monitor: every strobe must match the oldest expected event, cycle included.
  always @(negedge clk) begin
    if (!reset && (keys_press != 4'b0 || keys_release != 4'b0)) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_strobe @%0d: press=%b release=%b keys=%b", cyc, keys_press,
                 keys_release, keys);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.cyc != cyc || e.press !== keys_press || e.rel !== keys_release ||
            e.keys !== keys) begin
          fails++;
          $display("FAIL strobe: got cyc=%0d press=%b release=%b keys=%b, required cyc=%0d press=%b release=%b keys=%b",
                   cyc, keys_press, keys_release, keys, e.cyc, e.press, e.rel, e.keys);
        end
      end
    end
  end

  initial begin
    int unsigned c;
    // Reset with all keys released.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_zero("in_reset");
    end
    reset = 1'b0;
    wait_cyc(20);
    check_zero("idle_after_reset");

    // Key 0 pressed and held; released later.
    c = cyc;
    keys_raw = 4'b1110;
    push(c + 10, 4'b0001, 4'b0000, 4'b0001);
`ifdef KEY_AUTOREPEAT_EN
    for (int k = 30; k <= 60; k += 6) push(c + k, 4'b0001, 4'b0000, 4'b0001);
`endif
    wait_cyc(52);
    keys_raw = 4'b1111;
    push(c + 62, 4'b0000, 4'b0001, 4'b0000);
    wait_cyc(18);

    // Key 1 bounce: low 5, high 1, then held low.
    c = cyc;
    keys_raw = 4'b1101;
    wait_cyc(5);
    keys_raw = 4'b1111;
    wait_cyc(1);
    keys_raw = 4'b1101;
    push(c + 16, 4'b0010, 4'b0000, 4'b0010);
    tests++;
    if (keys !== 4'b0000) begin
      fails++;
      $display("FAIL bounce_level: keys=%b, required 0000", keys);
    end
    wait_cyc(14);
    keys_raw = 4'b1111;
    push(c + 30, 4'b0000, 4'b0010, 4'b0000);
    wait_cyc(16);

    // Keys 2 and 3 pressed together, then released together.
    c = cyc;
    keys_raw = 4'b0011;
    push(c + 10, 4'b1100, 4'b0000, 4'b1100);
    wait_cyc(15);
    keys_raw = 4'b1111;
    push(c + 25, 4'b0000, 4'b1100, 4'b0000);
    wait_cyc(16);
    tests++;
    if (keys !== 4'b0000) begin
      fails++;
      $display("FAIL level_after_release: keys=%b, required 0000", keys);
    end

    // Reset while key 0 is partway through qualification.
    keys_raw = 4'b1110;
    wait_cyc(7);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_zero("mid_count_reset");
    end
    c = cyc;
    reset = 1'b0;
    push(c + 10, 4'b0001, 4'b0000, 4'b0001);
    wait_cyc(15);
    keys_raw = 4'b1111;
    push(c + 25, 4'b0000, 4'b0001, 4'b0000);
    wait_cyc(20);

    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL missing_strobes: %0d expected events never seen, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
